sw_host_sequencer: RTL and testbench



---
 rtl/sw_host_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_sw_host_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_host_sequencer.sv
// sw_host_sequencer
// Host-side sequencer for the SmithWaterman core. After a single i_go pulse it
// loads T into the core, then for each parameter set fetches the parameter
// word, starts a scoring pass, streams the cyclic S sequence on the core's
// request handshake, and reports the first result of each pass.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   i_go                       start a batch (sampled only in IDLE)
//   i_num_runs, i_s_total      pass count (clamped to MAX_RUNS) and S length, latched on go
//   o_t_addr / i_t_data        T memory, 1-cycle synchronous read
//   o_s_addr / i_s_data        S memory, 1-cycle synchronous read
//   o_p_addr / i_p_data        parameter memory, 1-cycle synchronous read
//   o_set_t, o_start_cal       core command pulses
//   o_t, o_s, o_s_valid        T word, S word and its character count to the core
//   o_param                    parameter word for the current pass
//   i_busy, i_request_s        core status and S request
//   i_valid, i_result          core result handshake
//   o_result, o_result_valid   first result of each pass, with o_run_idx
//   o_busy, o_done, o_err      batch status
module sw_host_sequencer #(
  parameter int unsigned CHAR_BIT       = 2,
  parameter int unsigned CHARS_PER_WORD = 64,
  parameter int unsigned SV_W           = 7,
  parameter int unsigned T_W            = 18,
  parameter int unsigned T_ADDR_W       = 10,
  parameter int unsigned S_ADDR_W       = 8,
  parameter int unsigned MAX_RUNS       = 4,
  parameter int unsigned RUN_W          = 3,
  parameter int unsigned RES_W          = 16,
  parameter int unsigned TIMEOUT        = 1 << 24
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_go,
  input  logic [RUN_W-1:0]                   i_num_runs,
  input  logic [15:0]                        i_s_total,
  output logic [T_ADDR_W-1:0]                o_t_addr,
  input  logic [T_W-1:0]                     i_t_data,
  output logic [S_ADDR_W-1:0]                o_s_addr,
  input  logic [CHAR_BIT*CHARS_PER_WORD-1:0] i_s_data,
  output logic [RUN_W-2:0]                   o_p_addr,
  input  logic [15:0]                        i_p_data,
  output logic                               o_set_t,
  output logic                               o_start_cal,
  output logic [T_W-1:0]                     o_t,
  output logic [CHAR_BIT*CHARS_PER_WORD-1:0] o_s,
  output logic [SV_W-1:0]                    o_s_valid,
  output logic [15:0]                        o_param,
  input  logic                               i_busy,
  input  logic                               i_request_s,
  input  logic                               i_valid,
  input  logic [RES_W-1:0]                   i_result,
  output logic [RES_W-1:0]                   o_result,
  output logic                               o_result_valid,
  output logic [RUN_W-2:0]                   o_run_idx,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err
);

  localparam int unsigned S_W   = CHAR_BIT * CHARS_PER_WORD;
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  localparam int unsigned IDX_W = RUN_W - 1;

  typedef enum logic [3:0] {
    IDLE, SET_T, LOAD_T, P_FETCH, P_LATCH, START, RUN, NEXT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [RUN_W-1:0]    runs_q, runs_d;
  logic [15:0]         s_total_q, s_total_d;
  logic [15:0]         s_rem_q, s_rem_d;
  logic                sent_q, sent_d;
  logic                got_q, got_d;
  logic                timed_out, min_dwell;

  logic [T_ADDR_W-1:0] t_addr_d;
  logic [S_ADDR_W-1:0] s_addr_d;
  logic [IDX_W-1:0]    p_addr_d;
  logic [T_W-1:0]      t_d;
  logic [S_W-1:0]      s_d;
  logic [SV_W-1:0]     s_valid_d;
  logic [15:0]         param_d;
  logic [RES_W-1:0]    result_d;
  logic                result_valid_d;
  logic [IDX_W-1:0]    run_idx_d;
  logic                set_t_d, start_d, busy_d, done_d, err_d;

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    run_d          = run_q;
    runs_d         = runs_q;
    s_total_d      = s_total_q;
    s_rem_d        = s_rem_q;
    s_addr_d       = o_s_addr;
    sent_d         = 1'b0;
    got_d          = got_q;
    s_d            = '0;
    s_valid_d      = '0;
    param_d        = o_param;
    result_d       = o_result;
    result_valid_d = 1'b0;
    run_idx_d      = o_run_idx;
    err_d          = o_err;
    timed_out      = (cnt_q == CNT_W'(TIMEOUT - 1));
    min_dwell      = (cnt_q != '0);

    case (state_q)
      IDLE: begin
        if (i_go) begin
          state_d   = SET_T;
          runs_d    = (i_num_runs > RUN_W'(MAX_RUNS)) ? RUN_W'(MAX_RUNS) : i_num_runs;
          s_total_d = i_s_total;
          run_d     = '0;
          err_d     = 1'b0;
        end
      end
      SET_T: state_d = LOAD_T;
      LOAD_T: begin
        if (!i_busy && min_dwell) begin
          state_d = (runs_q == '0) ? DONE : P_FETCH;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      P_FETCH: state_d = P_LATCH;
      P_LATCH: begin
        param_d = i_p_data;
        state_d = START;
      end
      START: state_d = RUN;
      RUN: begin
        // One word per request, never in back-to-back cycles: the idle cycle
        // lets the S memory return the word at the new address.
        if (i_request_s && !sent_q) begin
          sent_d = 1'b1;
          s_d    = i_s_data;
          if (s_rem_q > 16'(CHARS_PER_WORD)) begin
            s_valid_d = {SV_W{1'b1}};
            s_addr_d  = o_s_addr + S_ADDR_W'(1);
            s_rem_d   = s_rem_q - 16'(CHARS_PER_WORD);
          end else begin
            // Tail word: S is cyclic, so rewind for a possible repeat pass.
            s_valid_d = SV_W'(s_rem_q);
            s_addr_d  = '0;
            s_rem_d   = s_total_q;
          end
        end
        // Only the first valid of a pass is reported.
        if (i_valid && !got_q) begin
          result_d       = i_result;
          result_valid_d = 1'b1;
          run_idx_d      = run_q[IDX_W-1:0];
          got_d          = 1'b1;
        end
        if (!i_busy && min_dwell) begin
          state_d = NEXT;
          if (!got_q && !i_valid) err_d = 1'b1;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      NEXT: begin
        run_d   = run_q + RUN_W'(1);
        state_d = (run_d < runs_q) ? P_FETCH : DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Entering START rewinds the S stream and re-arms result capture.
    if (state_d == START) begin
      s_addr_d = '0;
      s_rem_d  = s_total_q;
      got_d    = 1'b0;
    end

    // Watchdog counts dwell only in the phases the core controls.
    if (state_d != state_q || (state_q != LOAD_T && state_q != RUN)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // T address leads o_t by two cycles to cover the registered memory read.
    t_addr_d = (state_d == SET_T || state_d == LOAD_T) ? o_t_addr + T_ADDR_W'(1) : '0;
    t_d      = (state_d == LOAD_T) ? i_t_data : '0;
    p_addr_d = (state_d == P_FETCH) ? run_d[IDX_W-1:0] : o_p_addr;
    set_t_d  = (state_d == SET_T);
    start_d  = (state_d == START);
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      run_q          <= '0;
      runs_q         <= '0;
      s_total_q      <= '0;
      s_rem_q        <= '0;
      sent_q         <= 1'b0;
      got_q          <= 1'b0;
      o_t_addr       <= '0;
      o_s_addr       <= '0;
      o_p_addr       <= '0;
      o_t            <= '0;
      o_s            <= '0;
      o_s_valid      <= '0;
      o_param        <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_run_idx      <= '0;
      o_set_t        <= 1'b0;
      o_start_cal    <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      run_q          <= run_d;
      runs_q         <= runs_d;
      s_total_q      <= s_total_d;
      s_rem_q        <= s_rem_d;
      sent_q         <= sent_d;
      got_q          <= got_d;
      o_t_addr       <= t_addr_d;
      o_s_addr       <= s_addr_d;
      o_p_addr       <= p_addr_d;
      o_t            <= t_d;
      o_s            <= s_d;
      o_s_valid      <= s_valid_d;
      o_param        <= param_d;
      o_result       <= result_d;
      o_result_valid <= result_valid_d;
      o_run_idx      <= run_idx_d;
      o_set_t        <= set_t_d;
      o_start_cal    <= start_d;
      o_busy         <= busy_d;
      o_done         <= done_d;
      o_err          <= err_d;
    end
  end

endmodule

// File: tb/tb_sw_host_sequencer.sv
// Bench for sw_host_sequencer: memories and a scripted core, with expected
// values taken from a word/character model of the cyclic S stream.
module tb_sw_host_sequencer;

  localparam int unsigned TIMEOUT = 1500;

  logic         clk = 1'b0;
  logic         rst_n, i_go, i_busy, i_request_s, i_valid;
  logic [2:0]   i_num_runs;
  logic [15:0]  i_s_total, i_p_data, i_result, o_param, o_result;
  logic [9:0]   o_t_addr;
  logic [17:0]  i_t_data, o_t;
  logic [7:0]   o_s_addr;
  logic [127:0] i_s_data, o_s;
  logic [1:0]   o_p_addr, o_run_idx;
  logic [6:0]   o_s_valid;
  logic         o_set_t, o_start_cal, o_result_valid, o_busy, o_done, o_err;

  logic [17:0]  t_mem [1024];
  logic [127:0] s_mem [256];
  logic [15:0]  p_mem [4];

  int n_checks = 0;
  int n_pass   = 0;
  bit err_exp  = 0;

  sw_host_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_num_runs(i_num_runs), .i_s_total(i_s_total),
    .o_t_addr(o_t_addr), .i_t_data(i_t_data), .o_s_addr(o_s_addr), .i_s_data(i_s_data),
    .o_p_addr(o_p_addr), .i_p_data(i_p_data), .o_set_t(o_set_t), .o_start_cal(o_start_cal),
    .o_t(o_t), .o_s(o_s), .o_s_valid(o_s_valid), .o_param(o_param), .i_busy(i_busy),
    .i_request_s(i_request_s), .i_valid(i_valid), .i_result(i_result), .o_result(o_result),
    .o_result_valid(o_result_valid), .o_run_idx(o_run_idx), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories
  always @(posedge clk) begin
    i_t_data <= t_mem[o_t_addr];
    i_s_data <= s_mem[o_s_addr];
    i_p_data <= p_mem[o_p_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // go, SET_T and T load; ends in the last LOAD_T cycle with i_busy released
  task automatic load_phase(input int nr, input int stot, input int load_len);
    bit saw_zero = 0;
    i_num_runs = 3'(nr);
    i_s_total  = 16'(stot);
    i_go       = 1'b1;
    err_exp    = 0;
    step();
    i_go       = 1'b0;
    i_num_runs = 3'($urandom);
    i_s_total  = 16'($urandom);
    chk("set_t", o_set_t, 1);
    chk("busy_set_t", o_busy, 1);
    chk("err_cleared", o_err, 0);
    i_busy = 1'b1;
    for (int j = 0; j < load_len; j++) begin
      step();
      chk("t_word", o_t, t_mem[j % 1024]);
      if (o_t_addr == 10'd0) saw_zero = 1;
      if (j == 1) chk("go_ignored", o_set_t, 0);
      i_go = (j == 0);
      if (j == load_len - 1) i_busy = 1'b0;
    end
    i_go = 1'b0;
    if (load_len > 1024) chk("t_addr_wrap", saw_zero, 1);
  endtask

  // P_FETCH, P_LATCH, START; ends in the START cycle
  task automatic pass_head(input int run);
    step();
    chk("p_addr", o_p_addr, run);
    chk("no_early_start", o_start_cal, 0);
    step();
    step();
    chk("start_cal", o_start_cal, 1);
    chk("param", o_param, p_mem[run]);
  endtask

  // RUN for n cycles (busy drops in the last); res_at < 0 means no result
  task automatic run_pass(input int run, input int stot, input int n, input int res_at,
                          input logic [15:0] res, input bit hold_req);
    int           k   = 0;
    int           nw  = (stot + 63) / 64;
    int           w, rem;
    bit           prev = 0, req, erv = 0;
    logic [6:0]   ev  = '0;
    logic [127:0] ed  = '0;
    i_busy      = 1'b1;
    i_request_s = 1'b0;
    for (int i = 0; i <= n; i++) begin
      step();
      chk("s_valid", o_s_valid, ev);
      chk("s_data", o_s, ed);
      chk("result_valid", o_result_valid, erv);
      if (erv) begin
        chk("result", o_result, res);
        chk("run_idx", o_run_idx, run);
      end
      if (i == n) break;
      req = hold_req ? 1'b1 : 1'($urandom);
      i_request_s = req;
      if (req && !prev) begin
        w    = k % nw;
        rem  = stot - 64 * w;
        ev   = (rem > 64) ? 7'h7f : 7'(rem);
        ed   = s_mem[w];
        k++;
        prev = 1;
      end else begin
        ev   = '0;
        ed   = '0;
        prev = 0;
      end
      erv      = (i == res_at);
      i_valid  = (i == res_at) || (res_at >= 0 && i == res_at + 1);
      i_result = (i == res_at) ? res : ~res;
      i_busy   = (i < n - 1);
    end
    i_request_s = 1'b0;
    i_valid     = 1'b0;
    chk("no_done_in_next", o_done, 0);
    if (res_at < 0) err_exp = 1;
    chk("err_after_pass", o_err, err_exp);
  endtask

  task automatic end_batch();
    step();
    chk("done", o_done, 1);
    chk("err_at_done", o_err, err_exp);
    step();
    chk("done_once", o_done, 0);
    chk("idle_busy", o_busy, 0);
  endtask

  initial begin
    int nr, ne, stot, n, ra, cyc;
    for (int i = 0; i < 1024; i++) t_mem[i] = 18'($urandom);
    for (int i = 0; i < 256; i++) s_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) p_mem[i] = 16'($urandom);
    rst_n = 1'b0; i_go = 1'b0; i_busy = 1'b0; i_request_s = 1'b0; i_valid = 1'b0;
    i_num_runs = '0; i_s_total = '0; i_result = '0;
    repeat (3) step();
    chk("rst_busy", o_busy, 0);
    chk("rst_t_addr", o_t_addr, 0);
    chk("rst_param", o_param, 0);
    chk("rst_result", o_result, 0);
    chk("rst_err", o_err, 0);
    chk("rst_pulses", {o_set_t, o_start_cal, o_done, o_result_valid}, 0);
    rst_n = 1'b1;
    step();

    // Long T load with wrap; two passes with fixed params and results
    p_mem[0] = 16'h2211;
    p_mem[1] = 16'h3122;
    load_phase(2, 150, 1030);
    pass_head(0);
    run_pass(0, 150, 14, 5, 16'd17, 1);
    pass_head(1);
    run_pass(1, 150, 40, $urandom_range(2, 30), 16'd9, 0);
    end_batch();

    // Run count clamped to 4; S of exactly one word; pass 2 ends without a result
    for (int i = 0; i < 4; i++) p_mem[i] = 16'($urandom);
    load_phase(7, 64, 3);
    for (int r = 0; r < 4; r++) begin
      pass_head(r);
      n = $urandom_range(6, 30);
      run_pass(r, 64, n, (r == 2) ? -1 : $urandom_range(0, 5), 16'($urandom), r[0]);
    end
    end_batch();

    // One character past a word boundary
    load_phase(1, 65, 2);
    pass_head(0);
    run_pass(0, 65, 12, 3, 16'($urandom), 1);
    end_batch();

    // Zero passes: load then straight to DONE
    load_phase(0, 100, 4);
    end_batch();

    // Randomized batches
    for (int b = 0; b < 4; b++) begin
      nr   = $urandom_range(1, 7);
      ne   = (nr > 4) ? 4 : nr;
      stot = $urandom_range(1, 400);
      for (int i = 0; i < 4; i++) p_mem[i] = 16'($urandom);
      load_phase(nr, stot, $urandom_range(2, 8));
      for (int r = 0; r < ne; r++) begin
        pass_head(r);
        n  = $urandom_range(3, 40);
        ra = $urandom_range(0, n + 3);
        if (ra >= n) ra = -1;
        run_pass(r, stot, n, ra, 16'($urandom), 0);
      end
      end_batch();
    end

    // Core hangs in RUN: watchdog must end the batch with an error
    load_phase(1, $urandom_range(1, 300), 2);
    pass_head(0);
    i_busy      = 1'b1;
    i_request_s = 1'b1;
    cyc = 0;
    while (o_done !== 1'b1 && cyc < int'(TIMEOUT) + 10) begin
      step();
      cyc++;
    end
    chk("hang_done", o_done, 1);
    chk("hang_latency", (cyc >= int'(TIMEOUT)) && (cyc <= int'(TIMEOUT) + 2), 1);
    chk("hang_err", o_err, 1);
    i_busy      = 1'b0;
    i_request_s = 1'b0;
    step();
    chk("hang_idle", o_busy, 0);

    // Reset in the middle of RUN, then a fresh batch from T word 0
    p_mem[0] = 16'hA5C3;
    load_phase(2, 200, 3);
    pass_head(0);
    i_busy      = 1'b1;
    i_request_s = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_param", o_param, 0);
    chk("mid_rst_result", {o_result, o_run_idx}, 0);
    chk("mid_rst_err", o_err, 0);
    chk("mid_rst_s", {o_s, o_s_valid}, 0);
    chk("mid_rst_addr", {o_t_addr, o_s_addr, o_p_addr}, 0);
    chk("mid_rst_pulses", {o_set_t, o_start_cal, o_done, o_result_valid}, 0);
    rst_n       = 1'b1;
    i_busy      = 1'b0;
    i_request_s = 1'b0;
    step();
    load_phase(1, 130, 5);
    pass_head(0);
    run_pass(0, 130, 16, 4, 16'h1234, 1);
    end_batch();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
